pe_block: RTL and testbench
===========================

// Module: pe_block
// PURPOSE
//  - Output-stationary MAC column: NUM_ROWS PEs share one streamed ifmap byte; each row has its own weight stream.
//  - Each row computes ofmap[r] = bias[r] + sum_{k=0..DEPTH-1} ifmap[k]*weight[k][r] over DEPTH consecutive cycles.
//  - One i_en pulse starts a pass; valid flags finished results. Sits between the tile buffers and the ofmap writer.
// PARAMETERS
//  - NUM_ROWS  8   rows (PEs) = outputs per pass
//  - DEPTH     4   MAC steps per pass (reduction length)
//  - DW        8   ifmap/weight width, signed two's complement
//  - AW        32  bias/accumulator/ofmap width, signed
// PORTS
//  - clk     in   1              clock; single clock domain, rising edge
//  - rst     in   1              asynchronous, active-low reset
//  - ifmap   in   DW             activation for current step, shared by all rows
//  - weight  in   [NUM_ROWS][DW] per-row weight for current step
//  - bias    in   [NUM_ROWS][AW] per-row bias, sampled only in the i_en cycle
//  - i_en    in   1              start pulse; also marks step 0
//  - ofmap   out  [NUM_ROWS][AW] per-row accumulator/result
//  - valid   out  1              results in ofmap are final
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, step counter 0, every ofmap[r]=0, valid=0.
//  - FSM IDLE -> RUN -> DONE.
//    - IDLE/DONE + i_en: acc[r] <= bias[r] + ifmap*weight[r]; step<=1; valid<=0; go to RUN.
//    - RUN, no i_en: acc[r] <= acc[r] + ifmap*weight[r]; step++.
//    - RUN: the step=DEPTH-1 MAC goes to DONE and sets valid<=1 on the same edge.
//    - DONE: ofmap and valid held until next i_en.
//  - Timing: i_en sampled at edge E0, steps 1..DEPTH-1 at E1..E(DEPTH-1).
//    - valid rises after edge E(DEPTH-1), i.e. DEPTH-1 cycles after the i_en edge.
//  - Restart: i_en during RUN aborts the pass and restarts at step 0 with fresh bias; no partial valid.
//  - i_en in DONE: valid drops the next cycle and a new pass starts.
//  - Arithmetic: 8x8 signed product sign-extended to AW; sum wraps mod 2^AW; no saturation.
//  - Inputs outside an active step are ignored.
//  - ofmap is the live accumulator during RUN; it is meaningful only while valid=1.
//  - Reset mid-pass: clears everything immediately; the pass is lost.
// CONFIGURATION
//  - PE_RELU_EN defined: outputs are ReLU'd; ofmap[r] = (acc[r] < 0) ? 0 : acc[r].
//    - Combinational on the register output; accumulation stays signed.
//  - PE_RELU_EN undefined: ofmap[r] = acc[r], raw signed result.
// STRUCTURE
//  - Package pe_pkg: DW, AW, NUM_ROWS, DEPTH defaults, state enum {IDLE,RUN,DONE}, typedefs data_t and acc_t.
//  - Sub-module pe_mac: one row with an acc register, load-with-bias/accumulate control and ReLU option.
//    - Instantiated NUM_ROWS times by generate.
//  - The FSM and step counter live once in pe_block and drive a shared load/acc strobe.
// TESTING
//  - Reset: hold rst=0 with random inputs -> all ofmap=0, valid=0.
//  - Basic pass: bias[r]=r, ifmap=1,2,3,4, weight[k][r]=1 -> ofmap[r]=10+r, valid 3 cycles after i_en edge.
//  - Signed: ifmap=-128 x4, weight=-128 x4, bias=0 -> ofmap=0x00010000.
//  - Signed negative: ifmap=127, weight=-1, bias=0 -> -508 (0xFFFFFE04); with PE_RELU_EN -> 0.
//  - Wrap: bias=0x7FFFFFFF, ifmap=1, weight=1 x4 -> 0x80000003 without ReLU.
//  - Back-to-back passes: second i_en while valid=1 -> valid drops next cycle; second result independent of first.
//  - Restart: i_en at step 2 -> valid only DEPTH-1 cycles after the second i_en.
//  - Async reset: rst low mid-pass -> ofmap=0, valid=0, result lost.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and sizing for the pe_block MAC column.
package pe_pkg;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 32;
  localparam int unsigned STEP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [AW-1:0] acc_t;

  // Full-precision signed product, sign-extended to accumulator width.
  function automatic acc_t mac_product(data_t a, data_t b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return AW'(p);
  endfunction

endpackage

// File: rtl/pe_block_if.sv
// Streaming operand / result bundle between tile buffers, pe_block and the ofmap writer.
interface pe_block_if;
  import pe_pkg::*;

  data_t                ifmap;
  data_t [NUM_ROWS-1:0] weight;
  acc_t  [NUM_ROWS-1:0] bias;
  logic                 i_en;
  acc_t  [NUM_ROWS-1:0] ofmap;
  logic                 valid;

  modport master (output ifmap, weight, bias, i_en, input ofmap, valid);
  modport slave  (input ifmap, weight, bias, i_en, output ofmap, valid);

endinterface

// File: rtl/pe_mac.sv
// One output-stationary row: accumulator loaded with bias+product or accumulated.
// Optional PE_RELU_EN clamps negative results to zero on the output only.
module pe_mac
  import pe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  acc_en,
  input  data_t ifmap,
  input  data_t weight,
  input  acc_t  bias,
  output acc_t  ofmap
);

  acc_t acc_q;
  acc_t prod;

  assign prod = mac_product(ifmap, weight);

  // Load wins over accumulate so a restart always begins from fresh bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= bias + prod;
    end else if (acc_en) begin
      acc_q <= acc_q + prod;
    end
  end

`ifdef PE_RELU_EN
  assign ofmap = acc_q[AW-1] ? '0 : acc_q;
`else
  assign ofmap = acc_q;
`endif

endmodule

// File: rtl/pe_block.sv
// Output-stationary MAC column: shared ifmap, per-row weights, DEPTH-step reduction.
// Build option PE_RELU_EN selects ReLU'd outputs (see pe_mac).
module pe_block
  import pe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  pe_block_if.slave bus
);

  localparam logic [1:0]        ST_IDLE  = IDLE;
  localparam logic [1:0]        ST_RUN   = RUN;
  localparam logic [1:0]        ST_DONE  = DONE;
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LST = STEP_W'(DEPTH - 1);

  logic [1:0]        state_q, state_nxt;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic              valid_q, valid_nxt;
  logic              load_c, acc_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      step_q  <= step_nxt;
      valid_q <= valid_nxt;
    end
  end

  // i_en from any state (re)starts a pass; RUN finishes on the last step.
  always_comb begin
    state_nxt = state_q;
    step_nxt  = step_q;
    valid_nxt = valid_q;
    load_c    = 1'b0;
    acc_c     = 1'b0;
    if (bus.i_en) begin
      load_c    = 1'b1;
      step_nxt  = STEP_ONE;
      valid_nxt = 1'b0;
      state_nxt = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_c = 1'b1;
          if (step_q == STEP_LST) begin
            step_nxt  = '0;
            valid_nxt = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            step_nxt = step_q + STEP_ONE;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.valid = valid_q;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    pe_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .load   (load_c),
      .acc_en (acc_c),
      .ifmap  (bus.ifmap),
      .weight (bus.weight[r]),
      .bias   (bus.bias[r]),
      .ofmap  (bus.ofmap[r])
    );
  end

endmodule

// File: tb/tb_pe_block.sv
// Self-checking bench for pe_block: directed and random passes against a sum-of-products model.
module tb_pe_block;
  import pe_pkg::*;

  logic clk;
  logic rst;
  pe_block_if bus ();

  pe_block dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] tifm [DEPTH];
  logic signed [DW-1:0] tw   [DEPTH][NUM_ROWS];
  logic signed [AW-1:0] tbias[NUM_ROWS];
  logic        [AW-1:0] held [NUM_ROWS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected row result straight from the definition: bias + sum of products, wrapped, optional ReLU.
  function automatic logic [AW-1:0] model(input int r);
    longint s;
    logic [AW-1:0] e;
    s = longint'(tbias[r]);
    for (int k = 0; k < DEPTH; k++) s += longint'(tifm[k]) * longint'(tw[k][r]);
    e = s[AW-1:0];
`ifdef PE_RELU_EN
    if (e[AW-1]) e = '0;
`endif
    return e;
  endfunction

  task automatic rand_inputs();
    bus.ifmap = data_t'($urandom);
    for (int r = 0; r < NUM_ROWS; r++) begin
      bus.weight[r] = data_t'($urandom);
      bus.bias[r]   = acc_t'($urandom);
    end
  endtask

  task automatic drive_step(input int k, input logic en);
    bus.i_en  = en;
    bus.ifmap = tifm[k];
    for (int r = 0; r < NUM_ROWS; r++) begin
      bus.weight[r] = tw[k][r];
      bus.bias[r]   = en ? tbias[r] : acc_t'($urandom);
    end
  endtask

  // Full pass: i_en on step 0, valid low until DEPTH-1 edges later, then results checked.
  task automatic do_pass(input string tag);
    @(negedge clk);
    drive_step(0, 1'b1);
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      chk({tag, "_valid_low"}, 32'(bus.valid), 32'd0);
      drive_step(k, 1'b0);
    end
    @(negedge clk);
    bus.i_en = 1'b0;
    rand_inputs();
    chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
    for (int r = 0; r < NUM_ROWS; r++) begin
      chk($sformatf("%s_row%0d", tag, r), bus.ofmap[r], model(r));
      held[r] = model(r);
    end
  endtask

  task automatic set_uniform(input int ifm, input int w, input int b);
    for (int k = 0; k < DEPTH; k++) begin
      tifm[k] = data_t'(ifm);
      for (int r = 0; r < NUM_ROWS; r++) tw[k][r] = data_t'(w);
    end
    for (int r = 0; r < NUM_ROWS; r++) tbias[r] = acc_t'(b);
  endtask

  task automatic set_random();
    for (int k = 0; k < DEPTH; k++) begin
      tifm[k] = data_t'($urandom);
      for (int r = 0; r < NUM_ROWS; r++) tw[k][r] = data_t'($urandom);
    end
    for (int r = 0; r < NUM_ROWS; r++) tbias[r] = acc_t'($urandom);
  endtask

  initial begin
    rst      = 1'b0;
    bus.i_en = 1'b0;
    rand_inputs();

    // Reset held with random inputs, including i_en toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_en = logic'($urandom);
      rand_inputs();
    end
    @(negedge clk);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("reset_row%0d", r), bus.ofmap[r], 32'd0);
    bus.i_en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);

    // Basic: bias r, ifmap 1..4, weight 1 -> 10+r.
    set_uniform(0, 1, 0);
    for (int k = 0; k < DEPTH; k++) tifm[k] = data_t'(k + 1);
    for (int r = 0; r < NUM_ROWS; r++) tbias[r] = acc_t'(r);
    do_pass("basic");
    chk("basic_lit0", bus.ofmap[0], 32'd10);
    chk("basic_lit7", bus.ofmap[7], 32'd17);

    // Signed corners.
    set_uniform(-128, -128, 0);
    do_pass("sgn_min");
    chk("sgn_min_lit", bus.ofmap[3], 32'h0001_0000);

    set_uniform(127, -1, 0);
    do_pass("sgn_neg");
`ifdef PE_RELU_EN
    chk("sgn_neg_lit", bus.ofmap[5], 32'd0);
`else
    chk("sgn_neg_lit", bus.ofmap[5], 32'hFFFF_FE04);
`endif

    set_uniform(1, 1, 32'h7FFF_FFFF);
    do_pass("wrap");
`ifdef PE_RELU_EN
    chk("wrap_lit", bus.ofmap[2], 32'd0);
`else
    chk("wrap_lit", bus.ofmap[2], 32'h8000_0003);
`endif

    // DONE holds results while inputs churn.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_inputs();
      chk("hold_valid", 32'(bus.valid), 32'd1);
      chk("hold_row0", bus.ofmap[0], held[0]);
      chk("hold_row7", bus.ofmap[NUM_ROWS-1], held[NUM_ROWS-1]);
    end

    // Back-to-back random passes started straight from DONE.
    for (int p = 0; p < 6; p++) begin
      set_random();
      do_pass($sformatf("rnd%0d", p));
    end

    // Restart: abort a pass at step 2 with different operands.
    set_random();
    @(negedge clk);
    drive_step(0, 1'b1);
    @(negedge clk);
    drive_step(1, 1'b0);
    set_random();
    do_pass("restart");

    // Async reset in mid-pass, away from the clock edge.
    set_random();
    @(negedge clk);
    drive_step(0, 1'b1);
    @(negedge clk);
    drive_step(1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid), 32'd0);
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("arst_row%0d", r), bus.ofmap[r], 32'd0);
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    chk("arst_stay_valid", 32'(bus.valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_idle_valid", 32'(bus.valid), 32'd0);

    set_random();
    do_pass("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
